mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) round-robin arbiter in front of an asynchronous
// 16-bit SRAM. One access at a time: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        dbg_req,
  input  logic        cpu_we,
  input  logic        dbg_we,
  input  logic [19:0] cpu_addr,
  input  logic [19:0] dbg_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] cpu_rdata,
  output logic [15:0] dbg_rdata,
  output logic        cpu_ready,
  output logic        dbg_ready,
  output logic        busy,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic [1:0]  state_dbg
);

  // Handshake: a port's req is sampled only while IDLE; once granted, its
  // inputs are ignored until the one-cycle ready pulse in DONE.

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        gnt_dbg_q;
  logic        we_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic        any_req;
  logic        pick_dbg;
  logic        last_strobe;

  // gnt_dbg_q doubles as the round-robin pointer: it names the last winner.
  assign any_req     = cpu_req | dbg_req;
  assign pick_dbg    = dbg_req & (~cpu_req | ~gnt_dbg_q);
  assign last_strobe = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_dbg_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 20'd0;
      wdata_q   <= 16'd0;
      cpu_rdata <= 16'd0;
      dbg_rdata <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        gnt_dbg_q <= pick_dbg;
        we_q      <= pick_dbg ? dbg_we    : cpu_we;
        addr_q    <= pick_dbg ? dbg_addr  : cpu_addr;
        wdata_q   <= pick_dbg ? dbg_wdata : cpu_wdata;
      end
      if (state_q == SETUP) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (last_strobe && !we_q) begin
        if (gnt_dbg_q) dbg_rdata <= Data;
        else           cpu_rdata <= Data;
      end
    end
  end

  always_comb begin
    CE        = 1'b1;
    UB        = 1'b1;
    LB        = 1'b1;
    OE        = 1'b1;
    WE        = 1'b1;
    cpu_ready = 1'b0;
    dbg_ready = 1'b0;
    case (state_q)
      SETUP: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
      end
      ACCESS: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        OE = we_q;
        WE = ~we_q;
      end
      DONE: begin
        cpu_ready = ~gnt_dbg_q;
        dbg_ready = gnt_dbg_q;
      end
      default: ;
    endcase
  end

  // Write data stays on the bus through DONE so it outlives the WE rising edge.
  assign Data      = (we_q && state_q != IDLE) ? wdata_q : 16'hzzzz;
  assign ADDR      = addr_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: SRAM model, reads/writes, round-robin,
// mid-access reset, and strobe width / latency for WAIT_CYCLES = 1, 2, 15.
module tb_mem_arbiter;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (WAIT_CYCLES = 2)
  logic        cpu_req = 0, dbg_req = 0, cpu_we = 0, dbg_we = 0;
  logic [19:0] cpu_addr = 0, dbg_addr = 0;
  logic [15:0] cpu_wdata = 0, dbg_wdata = 0;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        cpu_ready, dbg_ready, busy, ce, ub, lb, oe, we;
  logic [19:0] addr;
  logic [1:0]  st;
  wire  [15:0] data;

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_we(cpu_we), .dbg_we(dbg_we),
    .cpu_addr(cpu_addr), .dbg_addr(dbg_addr), .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata), .cpu_ready(cpu_ready), .dbg_ready(dbg_ready),
    .busy(busy), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we), .ADDR(addr), .Data(data),
    .state_dbg(st)
  );

  // SRAM model: word 0x00005 preloaded with 0x0003
  logic [15:0] mem [0:255];
  assign data = (!ce && !oe) ? ((addr == 20'h00005) ? 16'h0003 : mem[addr[7:0]]) : 16'hzzzz;
  always @(posedge clk) if (!ce && !we) mem[addr[7:0]] <= data;

  // side DUTs for WAIT_CYCLES = 1 and 15, CPU reads only
  logic        w1_req = 0, w15_req = 0;
  logic [15:0] w1_crd, w1_drd, w15_crd, w15_drd;
  logic        w1_crdy, w1_drdy, w1_busy, w1_ce, w1_ub, w1_lb, w1_oe, w1_we;
  logic        w15_crdy, w15_drdy, w15_busy, w15_ce, w15_ub, w15_lb, w15_oe, w15_we;
  logic [19:0] w1_addr, w15_addr;
  logic [1:0]  w1_st, w15_st;
  wire  [15:0] w1_data, w15_data;
  assign w1_data  = (!w1_ce && !w1_oe)   ? 16'h1111 : 16'hzzzz;
  assign w15_data = (!w15_ce && !w15_oe) ? 16'h2222 : 16'hzzzz;

  mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(w1_req), .dbg_req(1'b0), .cpu_we(1'b0), .dbg_we(1'b0),
    .cpu_addr(20'h00001), .dbg_addr(20'h0), .cpu_wdata(16'h0), .dbg_wdata(16'h0),
    .cpu_rdata(w1_crd), .dbg_rdata(w1_drd), .cpu_ready(w1_crdy), .dbg_ready(w1_drdy),
    .busy(w1_busy), .CE(w1_ce), .UB(w1_ub), .LB(w1_lb), .OE(w1_oe), .WE(w1_we),
    .ADDR(w1_addr), .Data(w1_data), .state_dbg(w1_st)
  );

  mem_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(w15_req), .dbg_req(1'b0), .cpu_we(1'b0), .dbg_we(1'b0),
    .cpu_addr(20'h00002), .dbg_addr(20'h0), .cpu_wdata(16'h0), .dbg_wdata(16'h0),
    .cpu_rdata(w15_crd), .dbg_rdata(w15_drd), .cpu_ready(w15_crdy), .dbg_ready(w15_drdy),
    .busy(w15_busy), .CE(w15_ce), .UB(w15_ub), .LB(w15_lb), .OE(w15_oe), .WE(w15_we),
    .ADDR(w15_addr), .Data(w15_data), .state_dbg(w15_st)
  );

  // free-running monitors, sampled on the falling edge
  int oe_lo = 0, we_lo = 0, dual_cnt = 0, rdy_cnt = 0;
  always @(negedge clk) begin
    if (!oe) oe_lo++;
    if (!we) we_lo++;
    if (cpu_ready && dbg_ready) dual_cnt++;
    if (cpu_ready || dbg_ready) rdy_cnt++;
  end

  // scoreboard
  int n_total = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one-cycle request on one port, then follow it to its ready pulse
  task automatic do_access(input bit use_dbg, input bit wr, input logic [19:0] a,
                           input logic [15:0] wd, input logic [15:0] exp_rd);
    int lat, oe0, we0;
    bit seen;
    logic [15:0] other_before;
    logic [15:0] exp_v;
    if (!wr) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    if (use_dbg) begin
      dbg_req = 1; dbg_we = wr; dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = wr; cpu_addr = a; cpu_wdata = wd;
    end
    oe0 = oe_lo;
    we0 = we_lo;
    other_before = use_dbg ? cpu_rdata : dbg_rdata;
    @(posedge clk); #1;
    cpu_req = 0; dbg_req = 0;
    cpu_we = $urandom_range(0, 1); cpu_addr = 20'($urandom_range(0, 255));
    dbg_we = $urandom_range(0, 1); dbg_addr = 20'($urandom_range(0, 255));
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      lat++;
      @(negedge clk);
      if (use_dbg ? dbg_ready : cpu_ready) seen = 1;
      else @(posedge clk);
    end
    check("ready_seen", {31'b0, seen}, 1);
    check("latency", lat, 4);
    check("other_ready", {31'b0, use_dbg ? cpu_ready : dbg_ready}, 0);
    check("other_rdata_hold", {16'b0, use_dbg ? cpu_rdata : dbg_rdata}, {16'b0, other_before});
    if (wr) begin
      check("we_width", we_lo - we0, 2);
      check("oe_idle_on_write", oe_lo - oe0, 0);
      check("wdata_hold_done", {16'b0, data}, {16'b0, wd});
      check("we_high_done", {31'b0, we}, 1);
    end else begin
      check("oe_width", oe_lo - oe0, 2);
      exp_v = exp_q.pop_front();
      check("rdata", {16'b0, use_dbg ? dbg_rdata : cpu_rdata}, {16'b0, exp_v});
    end
    @(posedge clk);
    @(negedge clk);
    check("ready_one_cycle", {30'b0, cpu_ready, dbg_ready}, 0);
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_ctrl", {27'b0, ce, oe, we, ub, lb}, 32'h1f);
    check("idle_addr_hold", {12'b0, addr}, {12'b0, a});
    if (wr) check("data_released", {31'b0, data === wd}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, gap, l1, l15, o1, o15, r0;
    bit seen;

    // reset values
    #12;
    check("rst_ctrl", {27'b0, ce, oe, we, ub, lb}, 32'h1f);
    check("rst_addr", {12'b0, addr}, 0);
    check("rst_busy_ready", {29'b0, busy, cpu_ready, dbg_ready}, 0);
    check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    check("rst_state", {30'b0, st}, 0);
    @(negedge clk);
    rst_n = 1;

    // CPU read of preloaded word, debug write, CPU read-back, debug read
    do_access(0, 0, 20'h00005, 16'h0000, 16'h0003);
    do_access(1, 1, 20'h00010, 16'hABCD, 16'h0000);
    do_access(0, 0, 20'h00010, 16'h0000, 16'hABCD);
    do_access(1, 0, 20'h00005, 16'h0000, 16'h0003);

    // reset during the strobe of a write
    @(posedge clk); #1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 20'h00020; dbg_wdata = 16'h5A5A;
    @(posedge clk); #1;
    dbg_req = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (!we) seen = 1;
    end
    check("mid_rst_we_low", {31'b0, seen}, 1);
    r0 = rdy_cnt;
    rst_n = 0;
    #1;
    check("mid_rst_ctrl", {27'b0, ce, oe, we, ub, lb}, 32'h1f);
    check("mid_rst_busy_ready", {29'b0, busy, cpu_ready, dbg_ready}, 0);
    check("mid_rst_addr", {12'b0, addr}, 0);
    check("mid_rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    check("mid_rst_data_released", {31'b0, data === 16'h5A5A}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    check("mid_rst_no_ready", rdy_cnt - r0, 0);
    check("mid_rst_idle", {30'b0, st}, 0);

    // both ports held high from a fresh reset: CPU, DBG, CPU, DBG
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00005;
    dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00010;
    r0 = dual_cnt;
    for (k = 0; k < 4; k++) begin
      seen = 0;
      gap = 0;
      while (!seen && gap < 20) begin
        @(negedge clk);
        gap++;
        if (cpu_ready || dbg_ready) seen = 1;
      end
      check("rr_grant", {30'b0, cpu_ready, dbg_ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
      if (k > 0) check("rr_back_to_back_gap", gap, 5);
      if (k % 2 == 0) check("rr_cpu_rdata", {16'b0, cpu_rdata}, 32'h0003);
      else            check("rr_dbg_rdata", {16'b0, dbg_rdata}, 32'hABCD);
    end
    cpu_req = 0;
    dbg_req = 0;
    repeat (3) @(negedge clk);
    check("rr_no_dual_ready", dual_cnt - r0, 0);
    check("rr_idle_after", {31'b0, busy}, 0);

    // WAIT_CYCLES = 1 and 15
    @(posedge clk); #1;
    w1_req = 1; w15_req = 1;
    @(posedge clk); #1;
    w1_req = 0; w15_req = 0;
    l1 = 0; l15 = 0; o1 = 0; o15 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!w1_oe) o1++;
      if (!w15_oe) o15++;
      if (w1_crdy) l1 = c;
      if (w15_crdy) l15 = c;
      @(posedge clk);
    end
    check("w1_strobe", o1, 1);
    check("w1_latency", l1, 3);
    check("w1_rdata", {16'b0, w1_crd}, 32'h1111);
    check("w15_strobe", o15, 15);
    check("w15_latency", l15, 17);
    check("w15_rdata", {16'b0, w15_crd}, 32'h2222);
    check("wx_idle", {30'b0, w1_busy, w15_busy}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
